// File: rtl/alu_clk_ctrl_pkg.sv
// Shared definitions for the execution core: microcode states, ALU modes,
// jump conditions, phase encoding and the control-strobe bundle.
package alu_clk_ctrl_pkg;

  localparam int unsigned WIDTH = 8;

  typedef enum logic [7:0] {
    ST_FETCH_PC   = 8'd0,
    ST_FETCH_INST = 8'd1,
    ST_HALT       = 8'd2,
    ST_LOAD_ADDR  = 8'd3,
    ST_LOAD_DATA  = 8'd4,
    ST_STORE_ADDR = 8'd5,
    ST_STORE_DATA = 8'd6,
    ST_MOV        = 8'd7,
    ST_ALU_OUT    = 8'd8,
    ST_ALU_CMP    = 8'd9,
    ST_IMM_PC     = 8'd10,
    ST_IMM_LOAD   = 8'd11,
    ST_JUMP       = 8'd12,
    ST_PUSH_ADDR  = 8'd13,
    ST_PUSH_DATA  = 8'd14,
    ST_POP_INC    = 8'd15,
    ST_POP_ADDR   = 8'd16,
    ST_POP_DATA   = 8'd17
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOT  = 4'd5,
    ALU_SHL  = 4'd6,
    ALU_SHR  = 4'd7,
    ALU_INC  = 4'd8,
    ALU_DEC  = 4'd9,
    ALU_PASS = 4'd10
  } alu_mode_e;

  typedef enum logic [2:0] {
    JC_ALWAYS = 3'd0,
    JC_Z      = 3'd1,
    JC_NZ     = 3'd2,
    JC_C      = 3'd3,
    JC_NC     = 3'd4
  } jcond_e;

  typedef enum logic [1:0] {
    PH_CYCLE = 2'd0,
    PH_RAM   = 2'd1,
    PH_INT   = 2'd2,
    PH_IDLE  = 2'd3
  } phase_e;

  typedef struct packed {
    logic ii;
    logic ci;
    logic co;
    logic cs;
    logic rfi;
    logic rfo;
    logic eo;
    logic ee;
    logic mi;
    logic ro;
    logic ri;
    logic so;
    logic sd;
    logic si;
    logic halt;
  } ctrl_t;

  // Codes 5-7 are "never"
  function automatic logic jump_taken(input logic [2:0] cond, input logic z, input logic c);
    case (cond)
      JC_ALWAYS: return 1'b1;
      JC_Z:      return z;
      JC_NZ:     return ~z;
      JC_C:      return c;
      JC_NC:     return ~c;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_clk_ctrl_alu_core.sv
// Combinational ALU: result and carry/borrow for the selected mode.
module alu_core
  import alu_clk_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [3:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH:0] sum;

  // Result and carry per operation; unused modes yield zero with no carry
  always_comb begin
    result = '0;
    carry  = 1'b0;
    sum    = {1'b0, a} + {1'b0, b};
    case (mode)
      ALU_ADD:  begin result = sum[WIDTH-1:0]; carry = sum[WIDTH]; end
      ALU_SUB:  begin result = a - b;          carry = (a < b);    end
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOT:  result = ~a;
      ALU_SHL:  begin result = {a[WIDTH-2:0], 1'b0}; carry = a[WIDTH-1]; end
      ALU_SHR:  begin result = {1'b0, a[WIDTH-1:1]}; carry = a[0];       end
      ALU_INC:  begin result = a + WIDTH'(1); carry = (a == '1); end
      ALU_DEC:  begin result = a - WIDTH'(1); carry = (a == '0); end
      ALU_PASS: result = b;
      default:  begin result = '0; carry = 1'b0; end
    endcase
  end

endmodule

// File: rtl/alu_clk_ctrl.sv
// Execution core: phase/strobe generator, ALU with flag registers and
// combinational microcode decoder.
module alu_clk_ctrl
  import alu_clk_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       state,
  input  logic [2:0]       operand1,
  input  logic [2:0]       operand2,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       alu_mode,
  output logic             cycle_clk,
  output logic             ram_clk,
  output logic             internal_clk,
  output logic             halted,
  output logic [WIDTH-1:0] alu_out,
  output logic             alu_oe,
  output logic             flag_carry,
  output logic             flag_zero,
  output logic             c_ii,
  output logic             c_ci,
  output logic             c_co,
  output logic             c_cs,
  output logic             c_rfi,
  output logic             c_rfo,
  output logic             c_eo,
  output logic             c_ee,
  output logic             c_mi,
  output logic             c_ro,
  output logic             c_ri,
  output logic             c_so,
  output logic             c_sd,
  output logic             c_si,
  output logic             c_halt
);

  phase_e           phase_q, phase_d;
  logic             run_q, run_d;
  logic             halted_q, halted_d;
  logic             flag_c_q, flag_c_d;
  logic             flag_z_q, flag_z_d;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             active;
  logic             strobe_en;
  ctrl_t            ctrl_raw;
  ctrl_t            ctrl;
  logic             unused_operand2;

  assign unused_operand2 = ^operand2;

  alu_core #(.WIDTH(WIDTH)) u_alu_core (
    .mode   (alu_mode),
    .a      (in_a),
    .b      (in_b),
    .result (alu_result),
    .carry  (alu_carry)
  );

  // Strobes are silenced while reset is held or once the core has halted;
  // run_q delays the first phase-0 strobe until the first edge after release
  assign active    = reset & ~halted_q;
  assign strobe_en = active & run_q;

  // Microcode decode from state, operand1 and the registered flags
  always_comb begin
    ctrl_raw = '0;
    case (state)
      ST_FETCH_PC:   begin ctrl_raw.co  = 1'b1; ctrl_raw.mi  = 1'b1; end
      ST_FETCH_INST: begin ctrl_raw.ro  = 1'b1; ctrl_raw.ii  = 1'b1; ctrl_raw.ci = 1'b1; end
      ST_HALT:       ctrl_raw.halt = 1'b1;
      ST_LOAD_ADDR:  begin ctrl_raw.rfo = 1'b1; ctrl_raw.mi  = 1'b1; end
      ST_LOAD_DATA:  begin ctrl_raw.ro  = 1'b1; ctrl_raw.rfi = 1'b1; end
      ST_STORE_ADDR: begin ctrl_raw.rfo = 1'b1; ctrl_raw.mi  = 1'b1; end
      ST_STORE_DATA: begin ctrl_raw.rfo = 1'b1; ctrl_raw.ri  = 1'b1; end
      ST_MOV:        begin ctrl_raw.rfo = 1'b1; ctrl_raw.rfi = 1'b1; end
      ST_ALU_OUT:    begin ctrl_raw.eo  = 1'b1; ctrl_raw.rfi = 1'b1; ctrl_raw.ee = 1'b1; end
      ST_ALU_CMP:    ctrl_raw.ee = 1'b1;
      ST_IMM_PC:     begin ctrl_raw.co  = 1'b1; ctrl_raw.mi  = 1'b1; end
      ST_IMM_LOAD:   begin ctrl_raw.ro  = 1'b1; ctrl_raw.rfi = 1'b1; ctrl_raw.ci = 1'b1; end
      ST_JUMP: begin
        if (jump_taken(operand1, flag_z_q, flag_c_q)) begin
          ctrl_raw.ro = 1'b1;
          ctrl_raw.cs = 1'b1;
        end else begin
          ctrl_raw.ci = 1'b1;
        end
      end
      ST_PUSH_ADDR:  begin ctrl_raw.so  = 1'b1; ctrl_raw.mi  = 1'b1; end
      ST_PUSH_DATA:  begin ctrl_raw.rfo = 1'b1; ctrl_raw.ri  = 1'b1; ctrl_raw.sd = 1'b1; end
      ST_POP_INC:    ctrl_raw.si = 1'b1;
      ST_POP_ADDR:   begin ctrl_raw.so  = 1'b1; ctrl_raw.mi  = 1'b1; end
      ST_POP_DATA:   begin ctrl_raw.ro  = 1'b1; ctrl_raw.rfi = 1'b1; end
      default:       ctrl_raw = '0;
    endcase
    ctrl = active ? ctrl_raw : '0;
  end

  // Next-state: phase advance, flag load and halt capture on the internal phase
  always_comb begin
    phase_d  = phase_q;
    run_d    = run_q;
    halted_d = halted_q;
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    if (!halted_q) begin
      if (!run_q) begin
        run_d = 1'b1;
      end else begin
        phase_d = phase_e'(phase_q + 2'd1);
        if (phase_q == PH_INT) begin
          if (ctrl.ee) begin
            flag_c_d = alu_carry;
            flag_z_d = (alu_result == '0);
          end
          if (ctrl.halt) halted_d = 1'b1;
        end
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q  <= PH_CYCLE;
      run_q    <= 1'b0;
      halted_q <= 1'b0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      run_q    <= run_d;
      halted_q <= halted_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
    end
  end

  assign cycle_clk    = strobe_en & (phase_q == PH_CYCLE);
  assign ram_clk      = strobe_en & (phase_q == PH_RAM);
  assign internal_clk = strobe_en & (phase_q == PH_INT);
  assign halted       = halted_q;
  assign flag_carry   = flag_c_q;
  assign flag_zero    = flag_z_q;
  assign alu_out      = ctrl.eo ? alu_result : '0;
  assign alu_oe       = ctrl.eo;

  assign c_ii   = ctrl.ii;
  assign c_ci   = ctrl.ci;
  assign c_co   = ctrl.co;
  assign c_cs   = ctrl.cs;
  assign c_rfi  = ctrl.rfi;
  assign c_rfo  = ctrl.rfo;
  assign c_eo   = ctrl.eo;
  assign c_ee   = ctrl.ee;
  assign c_mi   = ctrl.mi;
  assign c_ro   = ctrl.ro;
  assign c_ri   = ctrl.ri;
  assign c_so   = ctrl.so;
  assign c_sd   = ctrl.sd;
  assign c_si   = ctrl.si;
  assign c_halt = ctrl.halt;

endmodule

// File: tb/tb_alu_clk_ctrl.sv
// Bench for alu_clk_ctrl: behavioural model compared every cycle, plus
// directed literal expectations.
module tb_alu_clk_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] state = 8'd200;
  logic [2:0] operand1 = '0, operand2 = '0;
  logic [7:0] in_a = '0, in_b = '0;
  logic [3:0] alu_mode = '0;
  logic       cycle_clk, ram_clk, internal_clk, halted, alu_oe, flag_carry, flag_zero;
  logic [7:0] alu_out;
  logic c_ii, c_ci, c_co, c_cs, c_rfi, c_rfo, c_eo, c_ee, c_mi, c_ro, c_ri, c_so, c_sd, c_si, c_halt;

  int checks = 0;
  int errors = 0;

  // Model state (m_*) and its value after the next edge (n_*)
  bit m_run, m_halt, m_fc, m_fz;
  int m_phase;
  bit n_run, n_halt, n_fc, n_fz;
  int n_phase;

  // Strobe bit positions in the compared vector
  localparam int II = 14, CI = 13, CO = 12, CS = 11, RFI = 10, RFO = 9, EO = 8, EE = 7,
                 MI = 6, RO = 5, RI = 4, SO = 3, SD = 2, SI = 1, HALT = 0;

  alu_clk_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .state(state), .operand1(operand1), .operand2(operand2),
    .in_a(in_a), .in_b(in_b), .alu_mode(alu_mode),
    .cycle_clk(cycle_clk), .ram_clk(ram_clk), .internal_clk(internal_clk), .halted(halted),
    .alu_out(alu_out), .alu_oe(alu_oe), .flag_carry(flag_carry), .flag_zero(flag_zero),
    .c_ii(c_ii), .c_ci(c_ci), .c_co(c_co), .c_cs(c_cs), .c_rfi(c_rfi), .c_rfo(c_rfo),
    .c_eo(c_eo), .c_ee(c_ee), .c_mi(c_mi), .c_ro(c_ro), .c_ri(c_ri), .c_so(c_so),
    .c_sd(c_sd), .c_si(c_si), .c_halt(c_halt)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] bv(input int i);
    return 15'(1) << i;
  endfunction

  // Strobe list per microcode state
  function automatic logic [14:0] ctrl_model(input int st, input int op1, input bit z, input bit c);
    bit taken;
    case (op1)
      0: taken = 1;
      1: taken = z;
      2: taken = !z;
      3: taken = c;
      4: taken = !c;
      default: taken = 0;
    endcase
    case (st)
      0, 10:  return bv(CO) | bv(MI);
      1:      return bv(RO) | bv(II) | bv(CI);
      2:      return bv(HALT);
      3, 5:   return bv(RFO) | bv(MI);
      4, 17:  return bv(RO) | bv(RFI);
      6:      return bv(RFO) | bv(RI);
      7:      return bv(RFO) | bv(RFI);
      8:      return bv(EO) | bv(RFI) | bv(EE);
      9:      return bv(EE);
      11:     return bv(RO) | bv(RFI) | bv(CI);
      12:     return taken ? (bv(RO) | bv(CS)) : bv(CI);
      13, 16: return bv(SO) | bv(MI);
      14:     return bv(RFO) | bv(RI) | bv(SD);
      15:     return bv(SI);
      default: return '0;
    endcase
  endfunction

  // ALU in plain integer arithmetic: returns {carry, result}
  function automatic logic [8:0] alu_model(input int mode, input int a, input int b);
    int r;
    bit c;
    r = 0; c = 0;
    case (mode)
      0:  begin r = a + b; c = (r > 255); end
      1:  begin r = a - b; c = (a < b); end
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = 255 - a;
      6:  begin r = a * 2; c = (a >= 128); end
      7:  begin r = a / 2; c = (a % 2 == 1); end
      8:  begin r = a + 1; c = (a == 255); end
      9:  begin r = a - 1; c = (a == 0); end
      10: r = b;
      default: begin r = 0; c = 0; end
    endcase
    r = r & 255;
    return {c, 8'(r)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [14:0] dut_ctrl();
    return {c_ii, c_ci, c_co, c_cs, c_rfi, c_rfo, c_eo, c_ee, c_mi, c_ro, c_ri, c_so, c_sd, c_si, c_halt};
  endfunction

  task automatic set_reset(input bit v);
    reset = v;
    if (!v) begin
      m_run = 0; m_halt = 0; m_fc = 0; m_fz = 0; m_phase = 0;
      n_run = 0; n_halt = 0; n_fc = 0; n_fz = 0; n_phase = 0;
    end
  endtask

  // Compare every output against the model at the falling edge; prepare next state
  task automatic sample();
    logic [14:0] ec;
    logic [8:0]  al;
    bit en;
    @(negedge clk);
    ec = (reset && !m_halt) ? ctrl_model(int'(state), int'(operand1), m_fz, m_fc) : '0;
    en = reset && !m_halt && m_run;
    al = alu_model(int'(alu_mode), int'(in_a), int'(in_b));
    chk("ctrl", 32'(dut_ctrl()), 32'(ec));
    chk("phase_strobes", {29'd0, cycle_clk, ram_clk, internal_clk},
        {29'd0, en && m_phase == 0, en && m_phase == 1, en && m_phase == 2});
    chk("halted", 32'(halted), 32'(m_halt));
    chk("alu_out", 32'(alu_out), ec[EO] ? 32'(al[7:0]) : 32'd0);
    chk("alu_oe", 32'(alu_oe), 32'(ec[EO]));
    chk("flags", {30'd0, flag_carry, flag_zero}, {30'd0, m_fc, m_fz});
    n_run = m_run; n_halt = m_halt; n_fc = m_fc; n_fz = m_fz; n_phase = m_phase;
    if (reset && !m_halt) begin
      if (!m_run) n_run = 1;
      else begin
        if (m_phase == 2) begin
          if (ec[EE]) begin n_fc = al[8]; n_fz = (al[7:0] == 0); end
          if (ec[HALT]) n_halt = 1;
        end
        n_phase = (m_phase + 1) % 4;
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    m_run = n_run; m_halt = n_halt; m_fc = n_fc; m_fz = n_fz; m_phase = n_phase;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  // Sample repeatedly until the model reaches the internal phase (bounded)
  task automatic sample_at_phase2();
    for (int k = 0; k < 8; k++) begin
      sample();
      if (m_run && m_phase == 2 && !m_halt) return;
      advance();
    end
    checks++;
    errors++;
    $display("FAIL wait_phase2: timeout waiting for internal phase");
  endtask

  initial begin
    logic [2:0] pat [4];
    pat[0] = 3'b100; pat[1] = 3'b010; pat[2] = 3'b001; pat[3] = 3'b000;

    #1;
    set_reset(0);
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("reset_strobes", {29'd0, cycle_clk, ram_clk, internal_clk}, 32'd0);
      chk("reset_halted", 32'(halted), 32'd0);
      advance();
    end
    state = 8'd0;
    sample();
    chk("reset_ctrl_zero", 32'(dut_ctrl()), 32'd0);
    advance();
    state = 8'd200;
    set_reset(1);
    step();
    for (int i = 0; i < 8; i++) begin
      sample();
      chk("strobe_seq", {29'd0, cycle_clk, ram_clk, internal_clk}, {29'd0, pat[i % 4]});
      advance();
    end

    // ADD FF+01
    state = 8'd8; alu_mode = 4'd0; in_a = 8'hFF; in_b = 8'h01;
    sample_at_phase2();
    chk("add_out", 32'(alu_out), 32'h00);
    chk("add_oe", 32'(alu_oe), 32'd1);
    advance();
    sample();
    chk("add_flags", {30'd0, flag_carry, flag_zero}, 32'b11);
    advance();

    // Jump on Z with Z=1
    state = 8'd12; operand1 = 3'd1;
    sample();
    chk("jz_taken", {29'd0, c_ro, c_cs, c_ci}, 32'b110);
    advance();

    // SUB 03-05
    state = 8'd8; alu_mode = 4'd1; in_a = 8'h03; in_b = 8'h05;
    sample_at_phase2();
    chk("sub_out", 32'(alu_out), 32'hFE);
    advance();
    sample();
    chk("sub_flags", {30'd0, flag_carry, flag_zero}, 32'b10);
    advance();

    // Jump on Z with Z=0
    state = 8'd12; operand1 = 3'd1;
    sample();
    chk("jz_not_taken", {29'd0, c_ro, c_cs, c_ci}, 32'b001);
    advance();

    // AND F0&0F
    state = 8'd8; alu_mode = 4'd2; in_a = 8'hF0; in_b = 8'h0F;
    sample_at_phase2();
    chk("and_out", 32'(alu_out), 32'h00);
    advance();
    sample();
    chk("and_flags", {30'd0, flag_carry, flag_zero}, 32'b01);
    advance();

    // State sweep (HALT exercised separately)
    for (int s = 0; s < 256; s++) begin
      if (s == 2) continue;
      state = 8'(s);
      operand1 = 3'($urandom_range(0, 7));
      alu_mode = 4'($urandom_range(0, 15));
      in_a = 8'($urandom); in_b = 8'($urandom);
      sample();
      if (s == 0) chk("sweep_fetch_pc", 32'(dut_ctrl()), 32'(bv(CO) | bv(MI)));
      if (s == 14) chk("sweep_push_data", 32'(dut_ctrl()), 32'(bv(RFO) | bv(RI) | bv(SD)));
      if (s >= 18) chk("sweep_unlisted", 32'(dut_ctrl()), 32'd0);
      advance();
    end

    // Randomized traffic with occasional asynchronous reset pulses
    for (int i = 0; i < 400; i++) begin
      state = 8'($urandom_range(0, 19));
      if (state == 8'd2) state = 8'd12;
      operand1 = 3'($urandom_range(0, 7));
      operand2 = 3'($urandom_range(0, 7));
      alu_mode = 4'($urandom_range(0, 15));
      in_a = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      in_b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      if (!reset) set_reset(1);
      else if ($urandom_range(0, 49) == 0) set_reset(0);
      step();
    end
    if (!reset) begin set_reset(1); step(); end

    // Halt
    state = 8'd2;
    sample_at_phase2();
    chk("halt_strobe", 32'(c_halt), 32'd1);
    advance();
    for (int i = 0; i < 20; i++) begin
      sample();
      chk("halted_hold", 32'(halted), 32'd1);
      chk("halted_quiet", {14'd0, dut_ctrl(), cycle_clk, ram_clk, internal_clk}, 32'd0);
      advance();
    end
    set_reset(0);
    sample();
    chk("halt_cleared", 32'(halted), 32'd0);
    advance();
    set_reset(1);
    state = 8'd200;
    for (int i = 0; i < 6; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
